// File: rtl/mux_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    typedef enum logic [1:0] {IDLE, SEL, CAPT} sched_state_t;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Output word channel of the scheduler: captured word, its source and valid/ready.
interface mux_rr_scheduler_if #(
    parameter int BIT          = 27,
    parameter int NUMBER_INPUT = 512
);
    import mux_sched_pkg::*;

    localparam int SEL_W = sel_w(NUMBER_INPUT);

    logic [BIT-1:0]   out_data;
    logic [SEL_W-1:0] out_src;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, out_src, out_valid, input out_ready);
    modport slave  (input out_data, out_src, out_valid, output out_ready);

endinterface

// File: rtl/mux_rr_scheduler_rr_find.sv
// Round-robin search: first set bit of req at or after ptr, wrapping to 0.
module rr_find
    import mux_sched_pkg::*;
#(
    parameter  int N     = 512,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++)
            mask[i] = (SEL_W'(i) >= ptr);
    end

    // Low half holds only requesters at/after ptr; the high half is the
    // unmasked fallback, so the lowest hit overall is the wrapped winner.
    always_comb begin
        int pos;
        dbl = {req, req & mask};
        pos = 0;
        for (int i = 2*N-1; i >= 0; i--)
            if (dbl[i]) pos = i;
        found = |req;
        idx   = (pos >= N) ? SEL_W'(pos - N) : SEL_W'(pos);
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of MUX_base.sel: arbitrate, settle, capture, hand off over valid/ready.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter  int BIT          = 27,
    parameter  int NUMBER_INPUT = 512,
    localparam int SEL_W        = sel_w(NUMBER_INPUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUMBER_INPUT-1:0] req,
    output logic [NUMBER_INPUT-1:0] ack,
    output logic [SEL_W-1:0]        sel,
    input  logic [BIT-1:0]          mux_out,
    output logic                    busy,
    mux_rr_scheduler_if.master      o
);

    sched_state_t     state;
    logic [SEL_W-1:0] ptr;
    logic [BIT-1:0]   out_data_q;
    logic [SEL_W-1:0] out_src_q;
    logic             out_valid_q;
    logic             found;
    logic [SEL_W-1:0] win;
    logic             xfer;

    rr_find #(.N(NUMBER_INPUT)) u_find (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    assign xfer        = (state == CAPT) && out_valid_q && o.out_ready;
    assign busy        = (state != IDLE);
    assign o.out_data  = out_data_q;
    assign o.out_src   = out_src_q;
    assign o.out_valid = out_valid_q;

    // ack is decoded from state so a reset kills it immediately.
    always_comb begin
        ack = '0;
        if (xfer) ack[out_src_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            sel         <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    sel   <= win;
                    state <= SEL;
                end
                SEL: begin
                    out_data_q  <= mux_out;
                    out_src_q   <= sel;
                    out_valid_q <= 1'b1;
                    state       <= CAPT;
                end
                CAPT: if (xfer) begin
                    out_valid_q <= 1'b0;
                    ptr         <= (out_src_q == SEL_W'(NUMBER_INPUT-1)) ? '0
                                                                         : out_src_q + SEL_W'(1);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
